// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/status controller for the async FIFO (wclk domain).
// Holds binary/Gray write pointers and derives full, almost-full, level and overflow.
module wptr_full_ctrl #(
    parameter int ADDR      = 3,
    parameter int AFULL_LVL = 6
) (
    input  logic            wclk,
    input  logic            wrst_n,
    input  logic            winc,
    input  logic            wovf_clr,
    input  logic [ADDR:0]   wq2_rptr,
    output logic            wen,
    output logic [ADDR-1:0] waddr,
    output logic [ADDR:0]   wptr,
    output logic            wfull,
    output logic            walmost_full,
    output logic [ADDR:0]   wlevel,
    output logic            woverflow
);

    localparam logic [ADDR:0] AFULL_V = (ADDR+1)'(AFULL_LVL);

    logic [ADDR:0] wbin_q, wbin_d;
    logic [ADDR:0] wptr_q, wptr_d;
    logic [ADDR:0] wlevel_q, wlevel_d;
    logic [ADDR:0] rbin_s;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q, wovf_d;

    // Gated by wrst_n so a write attempted during reset never reaches the memory.
    assign wen = winc & ~wfull_q & wrst_n;

    always_comb begin
        rbin_s[ADDR] = wq2_rptr[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
        end
    end

    always_comb begin
        wbin_d   = wbin_q + {{ADDR{1'b0}}, wen};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wfull_d  = (wptr_d == {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]});
        wlevel_d = wbin_d - rbin_s;
        wafull_d = (wlevel_d >= AFULL_V);
        wovf_d   = (winc & wfull_q) | (wovf_q & ~wovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ADDR-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: directed steps with a reference model
// feeding an expected-result queue that is compared after each wclk edge.
module tb_wptr_full_ctrl;

    localparam int ADDR      = 3;
    localparam int AFULL_LVL = 6;
    localparam int DEPTH     = 1 << ADDR;

    logic            wclk = 1'b0;
    logic            wrst_n;
    logic            winc;
    logic            wovf_clr;
    logic [ADDR:0]   wq2_rptr;
    logic            wen;
    logic [ADDR-1:0] waddr;
    logic [ADDR:0]   wptr;
    logic            wfull;
    logic            walmost_full;
    logic [ADDR:0]   wlevel;
    logic            woverflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR:0]   ptr;
        logic [ADDR-1:0] addr;
        logic            full;
        logic            afull;
        logic [ADDR:0]   level;
        logic            ovf;
    } exp_t;

    exp_t expQ[$];

    logic [ADDR:0] mBin;
    logic          mFull;
    logic          mOvf;

    wptr_full_ctrl #(.ADDR(ADDR), .AFULL_LVL(AFULL_LVL)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wovf_clr(wovf_clr),
        .wq2_rptr(wq2_rptr), .wen(wen), .waddr(waddr), .wptr(wptr),
        .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
        .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [ADDR:0] bin2gray(input logic [ADDR:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b = '0;
        for (int k = ADDR; k >= 0; k--) begin
            b[k] = g[k] ^ ((k == ADDR) ? 1'b0 : b[k+1]);
        end
        return b;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBin  = '0;
        mFull = 1'b0;
        mOvf  = 1'b0;
        expQ.delete();
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, then compare.
    task automatic applyStimulus(input logic inc, input logic clr, input logic [ADDR:0] rptr);
        exp_t e;
        logic [ADDR:0] nb;
        logic          acc;
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = rptr;
        acc      = inc & ~mFull;
        nb       = mBin + {{ADDR{1'b0}}, acc};
        e.ptr    = bin2gray(nb);
        e.addr   = nb[ADDR-1:0];
        e.level  = nb - gray2bin(rptr);
        e.full   = (e.level == (ADDR+1)'(DEPTH));
        e.afull  = (e.level >= (ADDR+1)'(AFULL_LVL));
        e.ovf    = (inc & mFull) | (mOvf & ~clr);
        expQ.push_back(e);
        #1;
        checkVal("wen", 32'(wen), 32'(acc));
        @(posedge wclk);
        mBin  = nb;
        mFull = e.full;
        mOvf  = e.ovf;
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (expQ.size() > 0) else begin
            errors++;
            $display("[TB] FAIL scoreboard: observed empty queue expected 1 entry");
            $error("[TB] scoreboard empty");
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal("wptr",         32'(wptr),         32'(e.ptr));
            checkVal("waddr",        32'(waddr),        32'(e.addr));
            checkVal("wfull",        32'(wfull),        32'(e.full));
            checkVal("walmost_full", 32'(walmost_full), 32'(e.afull));
            checkVal("wlevel",       32'(wlevel),       32'(e.level));
            checkVal("woverflow",    32'(woverflow),    32'(e.ovf));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_wen"},   32'(wen),          32'd0);
        checkVal({tag, "_waddr"}, 32'(waddr),        32'd0);
        checkVal({tag, "_wptr"},  32'(wptr),         32'd0);
        checkVal({tag, "_full"},  32'(wfull),        32'd0);
        checkVal({tag, "_afull"}, 32'(walmost_full), 32'd0);
        checkVal({tag, "_level"}, 32'(wlevel),       32'd0);
        checkVal({tag, "_ovf"},   32'(woverflow),    32'd0);
    endtask

    logic [ADDR:0] fillSeq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                   4'b0111, 4'b0101, 4'b0100, 4'b1100};

    initial begin
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        modelReset();
        #1;
        checkAllZero("rst_a");
        winc = 1'b0;
        #1;
        winc = 1'b1;
        #1;
        checkAllZero("rst_b");
        repeat (2) @(posedge wclk);
        #1;
        checkAllZero("rst_c");
        @(negedge wclk);
        wrst_n = 1'b1;
        winc   = 1'b0;

        // Fill from empty.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b0000);
            checkVal($sformatf("fill_wptr%0d", i), 32'(wptr), 32'(fillSeq[i]));
            if (i == 5) checkVal("fill_afull6", 32'(walmost_full), 32'd1);
            if (i == 4) checkVal("fill_afull5", 32'(walmost_full), 32'd0);
        end
        checkVal("fill_full", 32'(wfull), 32'd1);
        checkVal("fill_level", 32'(wlevel), 32'd8);

        // Overflow and clear priority.
        applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkVal("ovf_wptr", 32'(wptr), 32'b1100);
        checkVal("ovf_set", 32'(woverflow), 32'd1);
        applyStimulus(1'b1, 1'b1, 4'b0000);
        checkVal("ovf_set_wins", 32'(woverflow), 32'd1);
        applyStimulus(1'b0, 1'b1, 4'b0000);
        checkVal("ovf_cleared", 32'(woverflow), 32'd0);

        // Drain release: one read seen by the write side.
        applyStimulus(1'b0, 1'b0, 4'b0001);
        checkVal("drain_full", 32'(wfull), 32'd0);
        checkVal("drain_level", 32'(wlevel), 32'd7);
        applyStimulus(1'b1, 1'b0, 4'b0001);
        checkVal("drain_wptr", 32'(wptr), 32'b1101);
        checkVal("drain_refull", 32'(wfull), 32'd1);

        // Set overflow, then reset mid-cycle without a clock edge.
        applyStimulus(1'b1, 1'b0, 4'b0001);
        checkVal("pre_rst_ovf", 32'(woverflow), 32'd1);
        #2;
        wrst_n = 1'b0;
        #1;
        checkVal("midrst_wen", 32'(wen), 32'd0);
        checkAllZero("midrst");
        modelReset();
        #1;
        wrst_n = 1'b1;

        // First write after reset targets address 0, then wrap with level held at 2.
        winc     = 1'b1;
        wq2_rptr = bin2gray(4'd15);
        #1;
        checkVal("post_rst_waddr", 32'(waddr), 32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, bin2gray(mBin - 4'd1));
            checkVal($sformatf("wrap_level%0d", i), 32'(wlevel), 32'd2);
            checkVal($sformatf("wrap_full%0d", i), 32'(wfull), 32'd0);
            if (i == 14) checkVal("wrap_1000", 32'(wptr), 32'b1000);
            if (i == 15) checkVal("wrap_0000", 32'(wptr), 32'b0000);
            if (i == 16) checkVal("wrap_0001", 32'(wptr), 32'b0001);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and status controller for the async FIFO, in the `wclk` domain. It holds the binary and Gray write pointers and drives the memory write address and enable. It compares its next Gray pointer with the read pointer that the r2w synchronizer brought into this domain (`wq2_rptr`), and from that derives registered full, almost-full, occupancy and a sticky overflow flag. The Gray pointer `wptr` it produces is the source for the w2r synchronizer on the read side.

## Interface
- `ADDR`, default 3: address width. FIFO depth = 2^ADDR. Legal range: ADDR >= 2.
- `AFULL_LVL`, default 6: almost-full threshold in entries. Legal range: 1..2^ADDR.

Ports:
- `wclk` in 1: write clock.
- `wrst_n` in 1: asynchronous, active-low reset.
- `winc` in 1: write request from the producer.
- `wovf_clr` in 1: clears `woverflow` (synchronous, one-cycle pulse).
- `wq2_rptr` in ADDR+1: Gray read pointer, already synchronized into `wclk`.
- `wen` out 1: memory write enable, combinational: `winc & ~wfull`.
- `waddr` out ADDR: memory write address, equal to `wbin[ADDR-1:0]`.
- `wptr` out ADDR+1: registered Gray write pointer, sent to the w2r synchronizer.
- `wfull` out 1: registered full flag.
- `walmost_full` out 1: registered; high when occupancy >= AFULL_LVL.
- `wlevel` out ADDR+1: registered occupancy as seen from the write side, 0..2^ADDR.
- `woverflow` out 1: sticky flag, set when a write is attempted while full.

## Operation
- Internal `wbin` register, ADDR+1 bits wide. It wraps modulo 2^(ADDR+1).
- `wbin_next = wbin + (winc & ~wfull)`.
- `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- `wptr <= wgray_next` and `wbin <= wbin_next` on every `wclk` edge.
- Full test uses the standard two-MSB-inverted Gray compare:
  - `wfull <= (wgray_next == {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]})`.
- `rbin_s` = Gray-to-binary of `wq2_rptr`, combinational XOR prefix from the MSB down.
- `wlevel <= (wbin_next - rbin_s)` mod 2^(ADDR+1). The result is never above 2^ADDR.
- `walmost_full <= (wbin_next - rbin_s) >= AFULL_LVL`.
- Writes while full are blocked: `wen = 0` and the pointers hold.
- A write attempt while `wfull = 1` sets `woverflow` at the next edge.
- `wovf_clr` clears `woverflow`. If a set and `wovf_clr` occur in the same cycle, the set wins.
- `wq2_rptr` is the only cross-domain input and is treated as already synchronous. No combinational path runs from `wq2_rptr` to any output.
- Flag pessimism is by design:
  - `wfull` and `wlevel` lag actual reads by the 2-flop synchronizer delay plus one register stage.
  - The FIFO can therefore look full or fuller than it is, but never emptier. Overflow of the memory is impossible.

## Timing
- Reset (async assert, sync deassert external): `wbin = 0`, `wptr = 0`, `waddr = 0`, `wfull = 0`, `walmost_full = 0`, `wlevel = 0`, `woverflow = 0`.
- Reset takes effect immediately, with no clock, and also applies mid-operation. Any in-flight write attempt in that cycle is discarded.
- Write latency:
  - An accepted write (`wen = 1` at edge N) updates `waddr`, `wptr` and `wlevel` after edge N.
  - The memory captures data at edge N, at the old `waddr`.
- `wfull` rises after the edge that accepts the write filling the last entry. A `winc` in the very next cycle is already blocked.
- When `wq2_rptr` advances, `wfull`, `wlevel` and `walmost_full` update at the next `wclk` edge.
- Simultaneous `winc` and a `wq2_rptr` advance while full:
  - The write is blocked this cycle because `wfull` is still 1.
  - `wfull` drops at the next edge.
- `wen` is combinational from registered `wfull` and the input `winc`. No other combinational outputs exist.

## Test plan
- **Reset:** hold `wrst_n = 0`, toggle `winc` → all outputs 0, `wen = 0`, and values hold with no clock edge.
- **Fill** (ADDR = 3, AFULL_LVL = 6, `wq2_rptr = 0000`), 8 consecutive `winc` →
  - `wptr` sequence 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
  - `walmost_full = 1` after the 6th write.
  - `wfull = 1` and `wlevel = 8` after the 8th write.
- **Overflow:**
  - While full, `winc = 1` for 2 cycles → `wen = 0`, `wptr` stays 1100, `woverflow = 1`.
  - `wovf_clr` together with `winc` while full → `woverflow` stays 1.
  - `wovf_clr` alone → `woverflow = 0` at the next edge.
- **Drain release:** while full, set `wq2_rptr = 0001` →
  - Next edge: `wfull = 0`, `wlevel = 7`.
  - One write → `wptr = 1101`, `wfull = 1` again.
- **Wrap-around:** 20 writes with `wq2_rptr` following gray(wbin − 2) →
  - `wptr` passes 1000 → 0000 → 0001 correctly.
  - `wlevel` stays 2, `wfull` never asserts.
- **Mid-operation reset:** pulse `wrst_n` low while `wfull = 1` and `woverflow = 1` → all outputs 0 immediately. After release, the first `winc` writes to `waddr = 0`.
